multicycle_control_unit: RTL and testbench

Moore/Mealy control FSM that sequences the shared RV64I multicycle datapath (PC, IR, register file, single ALU, immediate generator, unified memory) for ld, sd, beq, R-type and I-type arithmetic. It sits beside the datapath, decodes the latched instruction, steers muxes, drives the immediate-format select, and handshakes with variable-latency memory. It also flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Control FSM for the shared RV64I multicycle datapath.
// Sequences fetch/decode/execute/memory/writeback for ld, sd, beq, R-type and
// I-type arithmetic, handshakes with variable-latency memory, parks in TRAP on
// an illegal opcode and counts retired instructions.
module multicycle_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_sel,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [CNT_W-1:0] retire_count,
  output logic [3:0]       state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] EXEC_R = 4'd2;
  localparam logic [3:0] EXEC_I = 4'd3;
  localparam logic [3:0] ADDR   = 4'd4;
  localparam logic [3:0] MEM_RD = 4'd5;
  localparam logic [3:0] MEM_WR = 4'd6;
  localparam logic [3:0] WB_ALU = 4'd7;
  localparam logic [3:0] WB_MEM = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] TRAP   = 4'd10;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [2:0] F3_DW   = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       retire;
  logic       unused_instr_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign state  = state_q;

  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  // Instructions retire on the edge that leaves their final state.
  assign retire = (state_q == WB_ALU) || (state_q == WB_MEM) ||
                  (state_q == BRANCH) || ((state_q == MEM_WR) && mem_ready);

  // State register; reset aborts any in-flight access and restarts at FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= next_state;
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

  // Next-state logic, including opcode dispatch out of DECODE.
  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OP_R)                          next_state = EXEC_R;
        else if (opcode == OP_I)                     next_state = EXEC_I;
        else if (opcode == OP_LD && funct3 == F3_DW) next_state = ADDR;
        else if (opcode == OP_SD && funct3 == F3_DW) next_state = ADDR;
        else if (opcode == OP_BR && funct3 == F3_BEQ) next_state = BRANCH;
        else                                         next_state = TRAP;
      end
      EXEC_R: next_state = WB_ALU;
      EXEC_I: next_state = WB_ALU;
      // opcode bit 5 separates sd (0100011) from ld (0000011)
      ADDR:   next_state = instruction[5] ? MEM_WR : MEM_RD;
      MEM_RD: next_state = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR: next_state = mem_ready ? FETCH : MEM_WR;
      WB_ALU: next_state = FETCH;
      WB_MEM: next_state = FETCH;
      BRANCH: next_state = FETCH;
      TRAP:   next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  // Datapath control decode; Mealy terms are ir_write/pc_write in FETCH and
  // pc_write in BRANCH.
  always_comb begin
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_sel    = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        // precompute the branch target into ALUOut
        alu_src_b = 2'b10;
        imm_sel   = 2'b11;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_sel   = {1'b0, instruction[5]};
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      WB_ALU: begin
        reg_write = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (counter narrowed to 4 bits so
// the wrap-around case is reachable).
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  localparam logic [31:0] I_ADDI = 32'h00A30293;
  localparam logic [31:0] I_LD   = 32'h00813183;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SD   = 32'h00313423;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_ADD  = 32'h002081B3;

  logic             clk;
  logic             reset;
  logic [31:0]      instruction;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_sel;
  logic             reg_write;
  logic             mem_to_reg;
  logic             trap;
  logic [CNT_W-1:0] retire_count;
  logic [3:0]       state;

  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .trap         (trap),
    .retire_count (retire_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    instruction = 32'h0;
    #2;
    check("rst_state",     state, 0);
    check("rst_mem_req",   mem_req, 1);
    check("rst_mem_read",  mem_read, 1);
    check("rst_alu_src_b", alu_src_b, 1);
    check("rst_iord",      iord, 0);
    check("rst_ir_write",  ir_write, 0);
    check("rst_pc_write",  pc_write, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_trap",      trap, 0);
    check("rst_retire",    retire_count, 0);
    mem_ready = 1'b1;
    #1;
    check("rst_ir_write_rdy", ir_write, 1);
    check("rst_pc_write_rdy", pc_write, 1);
    cyc();
    check("rst_hold_state", state, 0);

    // addi: FETCH, DECODE, EXEC_I, WB_ALU
    reset = 1'b1;
    instruction = I_ADDI;
    #1;
    check("addi_c1_state", state, 0);
    check("addi_c1_irw",   ir_write, 1);
    cyc();
    check("addi_c2_state", state, 1);
    check("addi_c2_srcb",  alu_src_b, 2);
    check("addi_c2_imm",   imm_sel, 3);
    check("addi_c2_srca",  alu_src_a, 0);
    check("addi_c2_req",   mem_req, 0);
    cyc();
    check("addi_c3_state", state, 3);
    check("addi_c3_srca",  alu_src_a, 1);
    check("addi_c3_srcb",  alu_src_b, 2);
    check("addi_c3_imm",   imm_sel, 0);
    check("addi_c3_op",    alu_op, 2);
    check("addi_c3_rw",    reg_write, 0);
    cyc();
    check("addi_c4_state", state, 7);
    check("addi_c4_rw",    reg_write, 1);
    check("addi_c4_m2r",   mem_to_reg, 0);
    cyc();
    check("addi_end_state",  state, 0);
    check("addi_end_rw",     reg_write, 0);
    check("addi_end_retire", retire_count, 1);

    // ld with two wait cycles in FETCH and in MEM_RD: 9 cycles
    instruction = I_LD;
    mem_ready = 1'b0;
    #1;
    check("ld_f1_state", state, 0);
    check("ld_f1_req",   mem_req, 1);
    check("ld_f1_irw",   ir_write, 0);
    cyc();
    check("ld_f2_state", state, 0);
    check("ld_f2_req",   mem_req, 1);
    check("ld_f2_iord",  iord, 0);
    cyc();
    mem_ready = 1'b1;
    #1;
    check("ld_f3_state", state, 0);
    check("ld_f3_irw",   ir_write, 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    check("ld_dec_state", state, 1);
    check("ld_dec_iord",  iord, 0);
    cyc();
    check("ld_addr_state", state, 4);
    check("ld_addr_imm",   imm_sel, 0);
    check("ld_addr_srca",  alu_src_a, 1);
    check("ld_addr_srcb",  alu_src_b, 2);
    check("ld_addr_req",   mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) begin
        mem_ready = 1'b1;
        #1;
      end
      check($sformatf("ld_rd%0d_state", i), state, 5);
      check($sformatf("ld_rd%0d_req", i),   mem_req, 1);
      check($sformatf("ld_rd%0d_read", i),  mem_read, 1);
      check($sformatf("ld_rd%0d_iord", i),  iord, 1);
      check($sformatf("ld_rd%0d_write", i), mem_write, 0);
    end
    cyc();
    check("ld_wb_state", state, 8);
    check("ld_wb_rw",    reg_write, 1);
    check("ld_wb_m2r",   mem_to_reg, 1);
    check("ld_wb_iord",  iord, 0);
    check("ld_wb_req",   mem_req, 0);
    cyc();
    check("ld_end_state",  state, 0);
    check("ld_end_retire", retire_count, 2);

    // beq taken then not taken: 3 cycles each
    for (int k = 0; k < 2; k++) begin
      instruction = I_BEQ;
      zero = 1'b0;
      #1;
      check($sformatf("beq%0d_f_state", k), state, 0);
      cyc();
      check($sformatf("beq%0d_dec_imm", k), imm_sel, 3);
      cyc();
      zero = (k == 0);
      #1;
      check($sformatf("beq%0d_br_state", k), state, 9);
      check($sformatf("beq%0d_br_pcw", k),   pc_write, (k == 0) ? 1 : 0);
      check($sformatf("beq%0d_br_pcsrc", k), pc_src, 1);
      check($sformatf("beq%0d_br_op", k),    alu_op, 1);
      check($sformatf("beq%0d_br_srca", k),  alu_src_a, 1);
      check($sformatf("beq%0d_br_srcb", k),  alu_src_b, 0);
      cyc();
      check($sformatf("beq%0d_end_state", k),  state, 0);
      check($sformatf("beq%0d_end_retire", k), retire_count, 3 + k);
    end
    zero = 1'b0;

    // sd with one wait cycle, retires on leaving MEM_WR
    instruction = I_SD;
    cyc();
    check("sd_dec_state", state, 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    check("sd_addr_state", state, 4);
    check("sd_addr_imm",   imm_sel, 1);
    cyc();
    check("sd_wr0_state", state, 6);
    check("sd_wr0_write", mem_write, 1);
    check("sd_wr0_read",  mem_read, 0);
    check("sd_wr0_iord",  iord, 1);
    check("sd_wr0_req",   mem_req, 1);
    cyc();
    check("sd_wr1_state",  state, 6);
    check("sd_wr1_retire", retire_count, 4);
    mem_ready = 1'b1;
    cyc();
    check("sd_end_state",  state, 0);
    check("sd_end_retire", retire_count, 5);

    // illegal opcode: TRAP is absorbing, counter frozen
    instruction = I_BAD;
    cyc();
    cyc();
    check("trap_state", state, 10);
    check("trap_flag",  trap, 1);
    check("trap_req",   mem_req, 0);
    check("trap_pcw",   pc_write, 0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      cyc();
      check($sformatf("trap_hold%0d_state", i),  state, 10);
      check($sformatf("trap_hold%0d_flag", i),   trap, 1);
      check($sformatf("trap_hold%0d_retire", i), retire_count, 5);
    end
    reset = 1'b0;
    #1;
    check("trap_rst_state",  state, 0);
    check("trap_rst_flag",   trap, 0);
    check("trap_rst_retire", retire_count, 0);
    cyc();
    reset = 1'b1;
    mem_ready = 1'b1;

    // reset during MEM_WR wait aborts the store
    instruction = I_SD;
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    cyc();
    check("abort_wr_state", state, 6);
    check("abort_wr_write", mem_write, 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_rst_state",  state, 0);
    check("abort_rst_write",  mem_write, 0);
    check("abort_rst_req",    mem_req, 1);
    check("abort_rst_read",   mem_read, 1);
    check("abort_rst_retire", retire_count, 0);
    cyc();
    reset = 1'b1;
    #1;
    check("abort_rel_state", state, 0);
    check("abort_rel_write", mem_write, 0);

    // 16 back-to-back R-type: 4-bit counter wraps 15 -> 0
    instruction = I_ADD;
    mem_ready = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("r%0d_f_state", i), state, 0);
      cyc();
      cyc();
      if (i == 0) begin
        check("r_exec_state", state, 2);
        check("r_exec_srca",  alu_src_a, 1);
        check("r_exec_srcb",  alu_src_b, 0);
        check("r_exec_op",    alu_op, 2);
      end
      cyc();
      check($sformatf("r%0d_wb_rw", i), reg_write, 1);
      cyc();
      exp_cnt = exp_cnt + 1'b1;
      check($sformatf("r%0d_retire", i), retire_count, exp_cnt);
    end
    check("r_wrap_zero", retire_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
